// File: rtl/pifo_req_dispatch.sv
// pifo_req_dispatch: host request front end for the multi-lane PIFO tree top.
//   Accepts one push/pop per cycle (i_req_valid/o_req_ready), routes it to
//   lane tree_id % LEVEL and drives that lane's o_push/o_pop strobe one cycle
//   after acceptance. A per-tree occupancy count lets it drop pops to empty
//   trees, pushes to full trees and illegal tree IDs (o_drop, o_drop_code,
//   saturating o_drop_cnt) instead of forwarding them.
//   Clock i_clk, asynchronous active-low reset i_arst_n.
module pifo_req_dispatch #(
    parameter  int PTW           = 16,
    parameter  int MTW           = 0,
    parameter  int LEVEL         = 3,
    parameter  int TREE_NUM      = 12,
    parameter  int OCC_MAX       = 14,
    parameter  int DCW           = 16,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int OCW           = $clog2(OCC_MAX + 1),
    localparam int DW            = MTW + PTW
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_op,
    input  logic [TREE_NUM_BITS-1:0] i_req_tree_id,
    input  logic [DW-1:0]            i_req_data,
    output logic [LEVEL-1:0]         o_push,
    output logic [LEVEL-1:0]         o_pop,
    output logic [TREE_NUM_BITS-1:0] o_push_tree_id [0:LEVEL-1],
    output logic [TREE_NUM_BITS-1:0] o_pop_tree_id  [0:LEVEL-1],
    output logic [DW-1:0]            o_push_data    [0:LEVEL-1],
    input  logic [LEVEL-1:0]         i_task_fifo_full,
    output logic                     o_drop,
    output logic [1:0]               o_drop_code,
    output logic [DCW-1:0]           o_drop_cnt
);
    localparam int LW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

    logic [OCW-1:0]           occ [TREE_NUM];
    logic [OCW-1:0]           cur_occ;
    logic [LW-1:0]            lane;
    logic [LW-1:0]            stage_lane;
    logic                     legal;
    logic                     accept;
    logic                     fwd;
    logic                     stage_valid;
    logic                     stage_op;
    logic [1:0]               code;
    logic [TREE_NUM_BITS-1:0] stage_id;
    logic [DW-1:0]            stage_data;

    // Blocking a lane while its previous request is staged spaces same-lane
    // requests by one cycle, which covers the one-cycle lag of the full flag.
    always_comb begin
        lane        = LW'(int'(i_req_tree_id) % LEVEL);
        legal       = int'(i_req_tree_id) < TREE_NUM;
        cur_occ     = legal ? occ[i_req_tree_id] : '0;
        o_req_ready = !legal || (!i_task_fifo_full[lane] && !(stage_valid && stage_lane == lane));
        accept      = i_req_valid && o_req_ready;
        code        = !legal                                  ? 2'b11 :
                      (!i_req_op && cur_occ == OCW'(OCC_MAX)) ? 2'b01 :
                      (i_req_op && cur_occ == '0)             ? 2'b10 : 2'b00;
        fwd         = accept && code == 2'b00;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stage_valid <= 1'b0;
            stage_lane  <= '0;
            stage_op    <= 1'b0;
            stage_id    <= '0;
            stage_data  <= '0;
            o_drop      <= 1'b0;
            o_drop_code <= 2'b00;
            o_drop_cnt  <= '0;
            for (int t = 0; t < TREE_NUM; t++) occ[t] <= '0;
        end else begin
            stage_valid <= fwd;
            if (fwd) begin
                stage_lane <= lane;
                stage_op   <= i_req_op;
                stage_id   <= i_req_tree_id;
                stage_data <= i_req_data;
                occ[i_req_tree_id] <= i_req_op ? cur_occ - 1'b1 : cur_occ + 1'b1;
            end
            o_drop      <= accept && !fwd;
            o_drop_code <= accept ? code : 2'b00;
            if (accept && !fwd && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    // Idle lanes present zeros on their ID/data outputs.
    always_comb begin
        for (int l = 0; l < LEVEL; l++) begin
            o_push[l]         = stage_valid && stage_lane == LW'(l) && !stage_op;
            o_pop[l]          = stage_valid && stage_lane == LW'(l) && stage_op;
            o_push_tree_id[l] = o_push[l] ? stage_id : '0;
            o_pop_tree_id[l]  = o_pop[l] ? stage_id : '0;
            o_push_data[l]    = o_push[l] ? stage_data : '0;
        end
    end
endmodule
